// File: rtl/fsm_multi_seq.sv
// Multi-channel Idle/Start/Stop/Clear sequence controller with per-channel input filters and a shared saturating completion counter.
// Optional macro FSM_TIMEOUT_EN adds per-channel dwell timeouts; without it tmo is tied low.
module fsm_multi_seq #(
    parameter int CH      = 4,
    parameter int FILT    = 3,
    parameter int CNT_W   = 8,
    parameter int TMO_CYC = 64
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [CH-1:0]     A,
    input  logic              cnt_clr,
    output logic [CH-1:0]     K2,
    output logic [CH-1:0]     K1,
    output logic [2*CH-1:0]   state_o,
    output logic [CNT_W-1:0]  done_cnt,
    output logic [CH-1:0]     tmo
);

    // Gray coded so every legal step flips a single bit
    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_START = 2'b01,
        S_STOP  = 2'b11,
        S_CLEAR = 2'b10
    } state_t;

    localparam int FW = $clog2(FILT + 1);
`ifdef FSM_TIMEOUT_EN
    localparam int DW = $clog2(TMO_CYC);
`endif
    localparam int SW = CNT_W + 5;

    genvar gi;
    generate
        for (gi = 0; gi < CH; gi++) begin : g_ch
            state_t          state_reg, state_next;
            logic [FW-1:0]   fcnt_reg, fcnt_next;
            logic            a_f_reg, a_f_next;
            logic            k1_reg, k1_next;
            logic            k2_reg, k2_next;
            logic            tmo_reg, tmo_next;
            logic            tmo_hit;
`ifdef FSM_TIMEOUT_EN
            logic [DW-1:0]   dwell_reg, dwell_next;
            logic            step_due;
`endif

            always_comb begin
                fcnt_next  = '0;
                a_f_next   = a_f_reg;
                state_next = state_reg;
                tmo_hit    = 1'b0;
                // input must disagree with the filtered value for FILT edges in a row
                if (A[gi] != a_f_reg) begin
                    if (fcnt_reg == FW'(FILT - 1))
                        a_f_next = A[gi];
                    else
                        fcnt_next = fcnt_reg + 1'b1;
                end

                case (state_reg)
                    S_IDLE:  if (a_f_reg)  state_next = S_START;
                    S_START: if (!a_f_reg) state_next = S_STOP;
                    S_STOP:  if (a_f_reg)  state_next = S_CLEAR;
                    S_CLEAR: if (!a_f_reg) state_next = S_IDLE;
                    default: state_next = S_IDLE;
                endcase

`ifdef FSM_TIMEOUT_EN
                step_due   = (state_next != state_reg);
                dwell_next = '0;
                if (state_reg != S_IDLE && !step_due) begin
                    if (dwell_reg == DW'(TMO_CYC - 1))
                        tmo_hit = 1'b1;
                    else
                        dwell_next = dwell_reg + 1'b1;
                end
                if (tmo_hit) begin
                    state_next = S_IDLE;
                    a_f_next   = 1'b0;
                    fcnt_next  = '0;
                end
`endif

                k2_next  = (state_reg == S_STOP)  && (state_next == S_CLEAR);
                k1_next  = (state_reg == S_CLEAR) && (state_next == S_IDLE) && !tmo_hit;
                tmo_next = tmo_hit;
            end

            always_ff @(posedge Clock) begin
                if (!Reset) begin
                    state_reg <= S_IDLE;
                    fcnt_reg  <= '0;
                    a_f_reg   <= 1'b0;
                    k1_reg    <= 1'b0;
                    k2_reg    <= 1'b0;
                    tmo_reg   <= 1'b0;
`ifdef FSM_TIMEOUT_EN
                    dwell_reg <= '0;
`endif
                end else begin
                    state_reg <= state_next;
                    fcnt_reg  <= fcnt_next;
                    a_f_reg   <= a_f_next;
                    k1_reg    <= k1_next;
                    k2_reg    <= k2_next;
                    tmo_reg   <= tmo_next;
`ifdef FSM_TIMEOUT_EN
                    dwell_reg <= dwell_next;
`endif
                end
            end

            assign state_o[2*gi +: 2] = state_reg;
            assign K1[gi]  = k1_reg;
            assign K2[gi]  = k2_reg;
            assign tmo[gi] = tmo_reg;
        end
    endgenerate

    logic [CNT_W-1:0] done_cnt_reg, done_cnt_next;
    logic [SW-1:0]    pop_cnt, sum_cnt;

    // counts the registered K1 pulses, so totals lag the pulse by one edge
    always_comb begin
        pop_cnt = '0;
        for (int i = 0; i < CH; i++)
            pop_cnt = pop_cnt + SW'(K1[i]);
        sum_cnt = SW'(done_cnt_reg) + pop_cnt;
        if (cnt_clr)
            done_cnt_next = '0;
        else if (sum_cnt > SW'({CNT_W{1'b1}}))
            done_cnt_next = {CNT_W{1'b1}};
        else
            done_cnt_next = sum_cnt[CNT_W-1:0];
    end

    always_ff @(posedge Clock) begin
        if (!Reset)
            done_cnt_reg <= '0;
        else
            done_cnt_reg <= done_cnt_next;
    end

    assign done_cnt = done_cnt_reg;

endmodule
